// File: rtl/clk_divider_monitor.sv
// Observes a divided clock from the fast domain: synchronizes it, strobes its edges,
// measures each half-period and tracks lock against the expected divider setting.
module clk_divider_monitor #(
  parameter int unsigned HALF_PERIOD = 1,
  parameter int unsigned TOLERANCE   = 0,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 inClk,
  input  logic                 inRst,
  input  logic                 inSlowClk,
  output logic                 outRise,
  output logic                 outFall,
  output logic [CNT_WIDTH-1:0] outHalf,
  output logic                 outValid,
  output logic                 outLocked,
  output logic                 outLost
);

  localparam int unsigned MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH:0]   HP_X      = (CNT_WIDTH + 1)'(HALF_PERIOD);
  localparam logic [CNT_WIDTH:0]   TOL_X     = (CNT_WIDTH + 1)'(TOLERANCE);
  localparam logic [MC_W-1:0]      LOCK_C    = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0]      MC_ONE    = MC_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;
  logic [CNT_WIDTH-1:0] half_q, half_d;
  logic                 valid_q, valid_d;
  logic                 locked_q, locked_d;
  logic                 lost_q, lost_d;

  logic                 ev_c;
  logic                 timeout_c;
  logic                 match_c;
  logic [CNT_WIDTH:0]   meas_x_c;
  logic [CNT_WIDTH:0]   diff_c;

  // State and output registers; synchronizer flops included
  always_ff @(posedge inClk) begin
    if (inRst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      half_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      sync1_q     <= inSlowClk;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      half_q      <= half_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      lost_q      <= lost_d;
    end
  end

  // Edge detection, half-period counter, match test and lock FSM
  always_comb begin
    ev_c        = sync2_q ^ prev_q;
    timeout_c   = (cnt_q == TIMEOUT_C);
    meas_x_c    = {1'b0, cnt_q};
    diff_c      = (meas_x_c >= HP_X) ? (meas_x_c - HP_X) : (HP_X - meas_x_c);
    match_c     = (diff_c <= TOL_X);

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    half_d      = half_q;
    valid_d     = 1'b0;
    rise_d      = sync2_q & ~prev_q;
    fall_d      = ~sync2_q & prev_q;

    if (ev_c) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    case (state_q)
      ST_IDLE, ST_LOST: begin
        // An edge here only establishes the reference for the next measurement
        if (ev_c) begin
          state_d     = ST_MEASURE;
          match_cnt_d = '0;
        end else if (timeout_c) begin
          state_d = ST_LOST;
        end
      end
      ST_MEASURE: begin
        if (ev_c) begin
          valid_d = 1'b1;
          half_d  = cnt_q;
          if (match_c) begin
            match_cnt_d = match_cnt_q + MC_ONE;
            if ((match_cnt_q + MC_ONE) == LOCK_C) begin
              state_d = ST_LOCKED;
            end
          end else begin
            match_cnt_d = '0;
          end
        end else if (timeout_c) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        if (ev_c) begin
          valid_d = 1'b1;
          half_d  = cnt_q;
          if (!match_c) begin
            state_d     = ST_MEASURE;
            match_cnt_d = '0;
          end
        end else if (timeout_c) begin
          state_d = ST_LOST;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        match_cnt_d = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    lost_d   = (state_d == ST_LOST);
  end

  assign outRise   = rise_q;
  assign outFall   = fall_q;
  assign outHalf   = half_q;
  assign outValid  = valid_q;
  assign outLocked = locked_q;
  assign outLost   = lost_q;

endmodule

// File: tb/tb_clk_divider_monitor.sv
// Bench for clk_divider_monitor: three instances (HP4/TOL0, HP4/TOL1, HP1/TOL0) share one
// divided clock; an event-level model predicts every output each cycle.
module tb_clk_divider_monitor;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        slow = 1'b0;

  logic        rise_w   [3];
  logic        fall_w   [3];
  logic [31:0] half_w   [3];
  logic        valid_w  [3];
  logic        locked_w [3];
  logic        lost_w   [3];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  clk_divider_monitor #(.HALF_PERIOD(4), .TOLERANCE(0), .LOCK_COUNT(4), .TIMEOUT(16), .CNT_WIDTH(32)) u0 (
    .inClk(clk), .inRst(rst), .inSlowClk(slow),
    .outRise(rise_w[0]), .outFall(fall_w[0]), .outHalf(half_w[0]),
    .outValid(valid_w[0]), .outLocked(locked_w[0]), .outLost(lost_w[0]));

  clk_divider_monitor #(.HALF_PERIOD(4), .TOLERANCE(1), .LOCK_COUNT(4), .TIMEOUT(16), .CNT_WIDTH(32)) u1 (
    .inClk(clk), .inRst(rst), .inSlowClk(slow),
    .outRise(rise_w[1]), .outFall(fall_w[1]), .outHalf(half_w[1]),
    .outValid(valid_w[1]), .outLocked(locked_w[1]), .outLost(lost_w[1]));

  clk_divider_monitor #(.HALF_PERIOD(1), .TOLERANCE(0), .LOCK_COUNT(4), .TIMEOUT(16), .CNT_WIDTH(32)) u2 (
    .inClk(clk), .inRst(rst), .inSlowClk(slow),
    .outRise(rise_w[2]), .outFall(fall_w[2]), .outHalf(half_w[2]),
    .outValid(valid_w[2]), .outLocked(locked_w[2]), .outLost(lost_w[2]));

  task automatic chk(input string nm, input int inst, input longint got, input longint want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("FAIL %s u%0d cyc %0d: got %0d want %0d", nm, inst, cyc, got, want);
    end
  endtask

  // Model: event times in fast cycles; an input change surfaces as a strobe two edges later
  int hp_m  [3] = '{4, 4, 1};
  int tol_m [3] = '{0, 1, 0};
  int lock_n = 4;
  int tmo_n  = 16;

  bit h1, h2, h3;
  bit have_ref [3];
  bit m_locked [3];
  bit m_lost   [3];
  int run      [3];
  int last_ev  [3];
  bit e_rise, e_fall;
  bit e_valid  [3];
  int e_half   [3];

  // Observations of u0 used by the literal checks
  int  vcnt0      = 0;
  int  lock_vcnt0 = -1;
  int  last_strb0 = 0;
  int  lost_at0   = 0;
  bit  plock0     = 1'b0;
  bit  plost0     = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      e_rise = 1'b0; e_fall = 1'b0;
      for (int i = 0; i < 3; i++) begin
        have_ref[i] = 1'b0; m_locked[i] = 1'b0; m_lost[i] = 1'b0;
        run[i] = 0; last_ev[i] = cyc + 1; e_valid[i] = 1'b0; e_half[i] = 0;
      end
    end else begin
      e_rise = h2 & ~h3;
      e_fall = ~h2 & h3;
      for (int i = 0; i < 3; i++) begin
        e_valid[i] = 1'b0;
        if (h2 != h3) begin
          if (have_ref[i]) begin
            int meas, d;
            meas = cyc - last_ev[i];
            d = meas - hp_m[i];
            if (d < 0) d = -d;
            e_half[i] = meas;
            e_valid[i] = 1'b1;
            if (d <= tol_m[i]) begin
              run[i]++;
              if (run[i] >= lock_n) m_locked[i] = 1'b1;
            end else begin
              run[i] = 0;
              m_locked[i] = 1'b0;
            end
          end else begin
            have_ref[i] = 1'b1;
            m_lost[i] = 1'b0;
            run[i] = 0;
          end
          last_ev[i] = cyc;
        end else if (!m_lost[i] && (cyc - last_ev[i] == tmo_n)) begin
          m_lost[i] = 1'b1;
          m_locked[i] = 1'b0;
          have_ref[i] = 1'b0;
        end
      end
      h3 = h2; h2 = h1; h1 = slow;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rise",   i, longint'(rise_w[i]),   longint'(e_rise));
      chk("fall",   i, longint'(fall_w[i]),   longint'(e_fall));
      chk("valid",  i, longint'(valid_w[i]),  longint'(e_valid[i]));
      chk("half",   i, longint'(half_w[i]),   longint'(e_half[i]));
      chk("locked", i, longint'(locked_w[i]), longint'(m_locked[i]));
      chk("lost",   i, longint'(lost_w[i]),   longint'(m_lost[i]));
    end
    if (rst) begin
      vcnt0 = 0; lock_vcnt0 = -1;
    end else begin
      if (valid_w[0]) vcnt0++;
      if (locked_w[0] && !plock0 && lock_vcnt0 < 0) lock_vcnt0 = vcnt0;
      if (rise_w[0] || fall_w[0]) last_strb0 = cyc;
      if (lost_w[0] && !plost0) lost_at0 = cyc;
    end
    plock0 = locked_w[0];
    plost0 = lost_w[0];
  end

  task automatic toggles(input int n, input int count);
    for (int k = 0; k < count; k++) begin
      repeat (n) @(negedge clk);
      slow = ~slow;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_half", 0, longint'(half_w[0]), 0);
    chk("rst_locked", 0, longint'(locked_w[0]), 0);
    rst = 1'b0;

    // Lock acquisition at 4-cycle toggling
    toggles(4, 12);
    repeat (3) @(negedge clk);
    chk("acq_locked", 0, longint'(locked_w[0]), 1);
    chk("acq_half", 0, longint'(half_w[0]), 4);
    chk("acq_valid_at_lock", 0, longint'(lock_vcnt0), 4);

    // Lock drop at 6-cycle toggling
    repeat (3) @(negedge clk);
    slow = ~slow;
    repeat (3) @(negedge clk);
    chk("drop_half", 0, longint'(half_w[0]), 6);
    chk("drop_locked", 0, longint'(locked_w[0]), 0);
    repeat (3) @(negedge clk);
    toggles(6, 7);
    repeat (3) @(negedge clk);
    chk("drop_norelock", 0, longint'(locked_w[0]), 0);

    // Tolerance: alternating 5/3 half-periods
    repeat (2) @(negedge clk);
    slow = ~slow;
    for (int k = 0; k < 9; k++) toggles((k % 2 == 0) ? 3 : 5, 1);
    repeat (3) @(negedge clk);
    chk("tol_locked", 1, longint'(locked_w[1]), 1);
    chk("tol_strict_unlocked", 0, longint'(locked_w[0]), 0);
    repeat (3) @(negedge clk);
    slow = ~slow;
    repeat (3) @(negedge clk);
    chk("tol_half6", 1, longint'(half_w[1]), 6);
    chk("tol_drop", 1, longint'(locked_w[1]), 0);

    // Loss and recovery
    repeat (1) @(negedge clk);
    slow = ~slow;
    toggles(4, 8);
    repeat (30) @(negedge clk);
    chk("loss_lost", 0, longint'(lost_w[0]), 1);
    chk("loss_locked", 0, longint'(locked_w[0]), 0);
    chk("loss_delay", 0, longint'(lost_at0 - last_strb0), 16);
    slow = ~slow;
    repeat (3) @(negedge clk);
    chk("recov_lost", 0, longint'(lost_w[0]), 0);
    repeat (1) @(negedge clk);
    slow = ~slow;
    toggles(4, 3);
    repeat (3) @(negedge clk);
    chk("recov_locked", 0, longint'(locked_w[0]), 1);

    // Edge lands on the timeout cycle
    repeat (13) @(negedge clk);
    slow = ~slow;
    repeat (3) @(negedge clk);
    chk("coll_half", 0, longint'(half_w[0]), 16);
    chk("coll_lost", 0, longint'(lost_w[0]), 0);
    chk("coll_locked", 0, longint'(locked_w[0]), 0);

    // Reset mid-lock
    repeat (1) @(negedge clk);
    slow = ~slow;
    toggles(4, 6);
    repeat (2) @(negedge clk);
    chk("prerst_locked", 0, longint'(locked_w[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_rise", 0, longint'(rise_w[0] | fall_w[0]), 0);
    chk("rst2_valid", 0, longint'(valid_w[0]), 0);
    chk("rst2_half", 0, longint'(half_w[0]), 0);
    chk("rst2_locked", 0, longint'(locked_w[0]), 0);
    chk("rst2_lost", 0, longint'(lost_w[0]), 0);
    rst = 1'b0;
    toggles(4, 8);
    repeat (3) @(negedge clk);
    chk("rst2_relock", 0, longint'(locked_w[0]), 1);

    // HALF_PERIOD = 1: an edge every fast cycle
    toggles(1, 20);
    repeat (3) @(negedge clk);
    chk("hp1_locked", 2, longint'(locked_w[2]), 1);
    chk("hp1_half", 2, longint'(half_w[2]), 1);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/clk_divider_monitor.md
# clk_divider_monitor

Fast-domain observer for the slow clocks our clock dividers produce. It takes a divided clock back into the fast domain through a 2-flop synchronizer and detects its edges as single-cycle strobes. It also measures every half-period in fast cycles and reports lock when the half-period matches the expected divider setting, or loss when the divided clock stops toggling. It sits beside each divider in the top level, and its strobes are the sanctioned way for fast-domain logic to act on slow-clock edges.

## Interface
- HALF_PERIOD, 1, expected fast cycles between consecutive edges of the divided clock (equals the divider's toggle count)
- TOLERANCE, 0, allowed absolute deviation of a measured half-period from HALF_PERIOD, in fast cycles
- LOCK_COUNT, 4, consecutive in-tolerance measurements required to declare lock (≥1)
- TIMEOUT, 16, fast cycles without an edge before declaring loss (> HALF_PERIOD + TOLERANCE)
- CNT_WIDTH, 32, width of the half-period counter and measurement output
- inClk  input  1  fast clock; all logic on its rising edge
- inRst  input  1  synchronous reset, active-high
- inSlowClk  input  1  divided clock under observation, asynchronous to inClk's sampling phase
- outRise  output  1  one-cycle strobe per synchronized rising edge of inSlowClk
- outFall  output  1  one-cycle strobe per synchronized falling edge of inSlowClk
- outHalf  output  CNT_WIDTH  most recent measured half-period, in fast cycles
- outValid  output  1  one-cycle strobe when outHalf is updated
- outLocked  output  1  high while in LOCKED
- outLost  output  1  high while in LOST

## Operation
- **Synchronizer:** sync1 ← inSlowClk, sync2 ← sync1, prev ← sync2; all reset to 0.
- **Edge event:** sync2 != prev; rise = sync2 & ~prev, fall = ~sync2 & prev.
- **Strobes:** outRise and outFall are registered and high for exactly one cycle per edge event.
- **Counter cnt:**
  - Set to 1 on an edge event.
  - Otherwise increment, saturating at 2^CNT_WIDTH−1.
  - Reset value 0.
- **Measurement:**
  - On an edge event in MEASURE or LOCKED, meas = cnt (pre-update value); outHalf ← meas and outValid pulses.
  - In IDLE or LOST the edge only starts the reference; there is no measurement and no outValid.
- **Match test:** |meas − HALF_PERIOD| ≤ TOLERANCE, computed unsigned with CNT_WIDTH+1 bits; no wrap.
- **FSM, reset state IDLE:**
  - IDLE: edge → MEASURE with matchCnt = 0. cnt reaches TIMEOUT with no edge → LOST.
  - MEASURE: edge with match → matchCnt+1, and when matchCnt+1 == LOCK_COUNT → LOCKED. Edge without match → matchCnt = 0. cnt == TIMEOUT with no edge → LOST.
  - LOCKED: edge without match → MEASURE with matchCnt = 0. cnt == TIMEOUT with no edge → LOST.
  - LOST: edge → MEASURE with matchCnt = 0; this edge is the reference only.
- **Simultaneous events:** an edge event in the same cycle cnt == TIMEOUT is treated as an edge; there is no timeout.
- **Reset mid-operation:** every register returns to its reset value on the next inClk edge with inRst high. In-flight edges are discarded.

## Timing
- Reset values:
  - outRise, outFall, outValid, outLocked, outLost = 0.
  - outHalf = 0; state IDLE; cnt = 0; matchCnt = 0.
- Edge latency:
  - An inSlowClk transition sampled at inClk edge n makes sync2 change at edge n+1.
  - The strobe, outValid and outHalf update register at edge n+2 and are visible for the cycle after it.
- outLocked and outLost are registered with the state and change in the same cycle as the outValid that caused the transition.
- Timeout:
  - cnt equals TIMEOUT exactly TIMEOUT−1 edges after the last edge event.
  - outLost goes high on the following edge.
- Half-period measurement: inSlowClk toggling every N fast cycles yields outHalf = N in steady state. N = 1 is supported, with an edge event every cycle.

## Test plan
- **Lock acquisition:** HALF_PERIOD=4, TOLERANCE=0, LOCK_COUNT=4, inSlowClk toggling every 4 cycles from reset.
  - First edge: no outValid.
  - Each later edge: outHalf=4 with outValid.
  - outLocked rises with the 5th edge's outValid.
  - outRise and outFall alternate.
- **Lock drop:** while locked, switch toggling to every 6 cycles. First outHalf=6 → outLocked=0 in the same cycle; no relock while the toggle count stays 6.
- **Tolerance:** TOLERANCE=1, HALF_PERIOD=4, half-periods alternating 3 and 5 → lock after 4 measurements. A half-period of 6 → back to MEASURE.
- **Loss and recovery:** TIMEOUT=16; hold inSlowClk after lock.
  - outLost=1 and outLocked=0 exactly 16 cycles after the last edge strobe.
  - Resume toggling every 4 cycles: outLost=0 after the first edge; relock after 4 further measurements.
- **Edge/timeout collision:** arrange an edge event in the cycle cnt==TIMEOUT → no outLost; measurement outHalf=16 reported.
- **Reset mid-lock, plus HALF_PERIOD=1:**
  - Assert inRst for 1 cycle while locked → all outputs 0 and outHalf=0 next cycle; lock resumes normally afterward.
  - With HALF_PERIOD=1 and toggling every cycle → strobes every cycle, outHalf=1, lock achieved.
